// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - registered ALU with iterative shift-add multiply and restoring divide
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       aluOpp,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ovf,
    output logic             divByZero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [3:0]       op_q, op_d;
    // acc: product (MUL) or partial remainder (DIV)
    // x:   shifted multiplicand (MUL) or dividend/quotient shift register (DIV)
    // y:   shifted multiplier (MUL) or divisor (DIV)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] sc_out;
    logic             sc_ovf, sc_dbz;
    logic             is_iter;

    logic [WIDTH-1:0] mul_acc_n, mul_x_n, mul_y_n;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] div_rem_n, div_quo_n;

    // single-cycle result and flags from the live operands
    always_comb begin
        sh     = in2[SHW-1:0];
        sum    = in1 + in2;
        diff   = in1 - in2;
        sc_out = '0;
        sc_ovf = 1'b0;
        sc_dbz = 1'b0;
        case (aluOpp)
            OP_ADD: begin
                sc_out = sum;
                sc_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_out = diff;
                sc_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_AND:  sc_out = in1 & in2;
            OP_OR:   sc_out = in1 | in2;
            OP_SLT:  sc_out = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SLTU: sc_out = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_XOR:  sc_out = in1 ^ in2;
            OP_NOR:  sc_out = ~(in1 | in2);
            OP_SLL:  sc_out = in1 << sh;
            OP_SRL:  sc_out = in1 >> sh;
            OP_SRA:  sc_out = $unsigned($signed(in1) >>> sh);
            // only reached as single-cycle when the divisor is zero
            OP_DIVU: begin
                sc_out = '1;
                sc_dbz = 1'b1;
            end
            OP_REMU: begin
                sc_out = in1;
                sc_dbz = 1'b1;
            end
            default: sc_out = '0;
        endcase
        is_iter = (aluOpp == OP_MUL) ||
                  (((aluOpp == OP_DIVU) || (aluOpp == OP_REMU)) && (in2 != '0));
    end

    // one shift-add and one restoring-divide step from the captured state
    always_comb begin
        mul_acc_n = acc_q + (y_q[0] ? x_q : '0);
        mul_x_n   = x_q << 1;
        mul_y_n   = y_q >> 1;
        rem_sh    = {acc_q, x_q[WIDTH-1]};
        trial     = rem_sh - {1'b0, y_q};
        if (!trial[WIDTH]) begin
            div_rem_n = trial[WIDTH-1:0];
            div_quo_n = {x_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_n = rem_sh[WIDTH-1:0];
            div_quo_n = {x_q[WIDTH-2:0], 1'b0};
        end
    end

    // next-state, iteration and result-register update
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        out_d   = out_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_iter) begin
                        op_d    = aluOpp;
                        count_d = '0;
                        acc_d   = '0;
                        x_d     = in1;
                        y_d     = in2;
                        state_d = ST_RUN;
                    end else begin
                        out_d  = sc_out;
                        zero_d = (sc_out == '0);
                        ovf_d  = sc_ovf;
                        dbz_d  = sc_dbz;
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                count_d = count_q + SHW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc_n;
                    x_d   = mul_x_n;
                    y_d   = mul_y_n;
                end else begin
                    acc_d = div_rem_n;
                    x_d   = div_quo_n;
                end
                if (count_q == SHW'(WIDTH-1)) begin
                    if (op_q == OP_MUL) begin
                        out_d = mul_acc_n;
                    end else if (op_q == OP_DIVU) begin
                        out_d = div_quo_n;
                    end else begin
                        out_d = div_rem_n;
                    end
                    zero_d  = (out_d == '0);
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and result registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign out       = out_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign divByZero = dbz_q;

endmodule
